// File: rtl/gen_fifo_defines_pkg.sv
// Shared definitions for the funct_generator datapath and its command sequencer.
package gen_fifo_defines_pkg;

    localparam int unsigned SEQ_CNT_WIDTH = 16;
    localparam int unsigned SEL_WIDTH     = 2;

    localparam logic [SEL_WIDTH-1:0] SEL_SIN   = 2'b00;
    localparam logic [SEL_WIDTH-1:0] SEL_COS   = 2'b01;
    localparam logic [SEL_WIDTH-1:0] SEL_TRIAN = 2'b10;
    localparam logic [SEL_WIDTH-1:0] SEL_SQUA  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        CLEAR,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/gen_sample_counter.sv
// Sample counter: clear, increment, and terminal count when the next increment reaches len.
module gen_sample_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] len,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    // len == 0 means continuous: count wraps and never terminates.
    assign tc_c = inc && (len != '0) && ((cnt + W'(1)) == len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/funct_generator_seq_ctrl.sv
// Command sequencer for funct_generator: amplitude config, address clear, then throttled address stepping.
module funct_generator_seq_ctrl
    import gen_fifo_defines_pkg::*;
#(
    parameter int unsigned INT_BITS  = 8,
    parameter int unsigned LUT_ADDR  = 8,
    parameter int unsigned CNT_WIDTH = SEQ_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_sel_i,
    input  logic [INT_BITS-1:0]  cmd_amp_i,
    input  logic [CNT_WIDTH-1:0] cmd_len_i,
    input  logic                 abort_i,
    input  logic                 fifo_full_i,
    output logic [1:0]           sel_o,
    output logic [INT_BITS-1:0]  amp_o,
    output logic                 en_config_amp_o,
    output logic                 clrh_addr_o,
    output logic                 enh_gen_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] sample_cnt_o
);

    // The generator wraps its own LUT address, so only a sanity bound is needed here.
    if (LUT_ADDR == 0) begin : g_bad_lut_addr
        $error("LUT_ADDR must be nonzero");
    end

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [CNT_WIDTH-1:0] len_q;
    logic                 cnt_clr;
    logic                 enh_c;
    logic                 tc_c;

    gen_sample_counter #(
        .W (CNT_WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (enh_c),
        .len  (len_q),
        .cnt  (sample_cnt_o),
        .tc_c (tc_c)
    );

    // Next-state decode; enh is the only output that follows inputs combinationally.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        enh_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = CONFIG;
                    cnt_clr = 1'b1;
                end
            end
            CONFIG: state_d = abort_i ? DONE : CLEAR;
            CLEAR:  state_d = abort_i ? DONE : RUN;
            RUN: begin
                if (abort_i) begin
                    state_d = DONE;
                end else begin
                    enh_c = !fifo_full_i;
                    if (tc_c) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enh_gen_o = enh_c;

    // Strobes are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            len_q           <= '0;
            sel_o           <= '0;
            amp_o           <= '0;
            en_config_amp_o <= 1'b0;
            clrh_addr_o     <= 1'b0;
            done_o          <= 1'b0;
            busy_o          <= 1'b0;
            cmd_ready_o     <= 1'b1;
        end else begin
            state_q         <= state_d;
            en_config_amp_o <= (state_d == CONFIG);
            clrh_addr_o     <= (state_d == CLEAR);
            done_o          <= (state_d == DONE);
            busy_o          <= (state_d != IDLE);
            cmd_ready_o     <= (state_d == IDLE);
            if ((state_q == IDLE) && cmd_valid_i) begin
                sel_o <= cmd_sel_i;
                amp_o <= cmd_amp_i;
                len_q <= cmd_len_i;
            end
        end
    end

endmodule

// File: tb/tb_funct_generator_seq_ctrl.sv
// Scoreboard bench for funct_generator_seq_ctrl: directed commands, per-cycle strobe/handshake monitors.
module tb_funct_generator_seq_ctrl;
    import gen_fifo_defines_pkg::*;

    localparam int unsigned IB  = 8;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW2 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_valid2 = 1'b0;
    logic [1:0]    cmd_sel = '0;
    logic [IB-1:0] cmd_amp = '0;
    logic [CW-1:0] cmd_len = '0;
    logic          abort = 1'b0;
    logic          fifo_full = 1'b0;

    logic          ready, cfg, clr, enh, busy, done;
    logic [1:0]    sel;
    logic [IB-1:0] amp;
    logic [CW-1:0] cnt;

    logic           ready2, cfg2, clr2, enh2, busy2, done2;
    logic [1:0]     sel2;
    logic [IB-1:0]  amp2;
    logic [CW2-1:0] cnt2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    funct_generator_seq_ctrl #(.INT_BITS(IB), .LUT_ADDR(8), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready),
        .cmd_sel_i(cmd_sel), .cmd_amp_i(cmd_amp), .cmd_len_i(cmd_len),
        .abort_i(abort), .fifo_full_i(fifo_full), .sel_o(sel), .amp_o(amp),
        .en_config_amp_o(cfg), .clrh_addr_o(clr), .enh_gen_o(enh),
        .busy_o(busy), .done_o(done), .sample_cnt_o(cnt)
    );

    funct_generator_seq_ctrl #(.INT_BITS(IB), .LUT_ADDR(8), .CNT_WIDTH(CW2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid2), .cmd_ready_o(ready2),
        .cmd_sel_i(cmd_sel), .cmd_amp_i(cmd_amp), .cmd_len_i(cmd_len[CW2-1:0]),
        .abort_i(abort), .fifo_full_i(fifo_full), .sel_o(sel2), .amp_o(amp2),
        .en_config_amp_o(cfg2), .clrh_addr_o(clr2), .enh_gen_o(enh2),
        .busy_o(busy2), .done_o(done2), .sample_cnt_o(cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cnt; int sel; int amp;
        int n_cfg; int n_clr; int n_enh;
        int cfg_lat; int clr_lat; int first_enh; int last_enh; int done_lat;
    } exp_t;

    exp_t exp_q[$];
    int   exp2_q[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int s, input int a, input int nc, input int nl,
                        input int ne, input int lc, input int ll, input int fe, input int le,
                        input int dl);
        exp_t e;
        e.cnt = c; e.sel = s; e.amp = a; e.n_cfg = nc; e.n_clr = nl; e.n_enh = ne;
        e.cfg_lat = lc; e.clr_lat = ll; e.first_enh = fe; e.last_enh = le; e.done_lat = dl;
        exp_q.push_back(e);
    endtask

    // Issue one command on the main DUT; returns in the CONFIG cycle (latency 1).
    task automatic send(input logic [1:0] s, input logic [IB-1:0] a, input logic [CW-1:0] l);
        cmd_sel = s; cmd_amp = a; cmd_len = l; cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    // Main monitor: per-cycle invariants, counter model, and per-command scoreboard at done.
    int acc = 0, in_cmd = 0, n_cfg = 0, n_clr = 0, n_enh = 0;
    int cfg_lat = -1, clr_lat = -1, first_enh = -1, last_enh = -1;
    logic [CW-1:0] mcnt = '0;
    always @(negedge clk) begin
        if (rst) begin
            in_cmd = 0; mcnt = '0;
        end else begin
            int lat;
            exp_t e;
            lat = cyc - acc;
            chk("strobe_onehot", int'(cfg) + int'(clr) + int'(enh), int'(cfg || clr || enh));
            chk("clr_enh_excl", int'(clr && enh), 0);
            chk("ready", int'(ready), int'(in_cmd == 0));
            chk("busy", int'(busy), in_cmd);
            chk("cnt_model", int'(cnt), int'(mcnt));
            if (cfg) begin n_cfg++; cfg_lat = lat; end
            if (clr) begin n_clr++; clr_lat = lat; end
            if (enh) begin
                n_enh++;
                if (first_enh < 0) first_enh = lat;
                last_enh = lat;
                mcnt = mcnt + CW'(1);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cnt", int'(cnt), e.cnt);
                    chk("done_sel", int'(sel), e.sel);
                    chk("done_amp", int'(amp), e.amp);
                    chk("n_cfg", n_cfg, e.n_cfg);
                    chk("n_clr", n_clr, e.n_clr);
                    chk("n_enh", n_enh, e.n_enh);
                    chk("cfg_lat", cfg_lat, e.cfg_lat);
                    chk("clr_lat", clr_lat, e.clr_lat);
                    chk("first_enh_lat", first_enh, e.first_enh);
                    chk("last_enh_lat", last_enh, e.last_enh);
                    chk("done_lat", lat, e.done_lat);
                end
                in_cmd = 0;
            end
            if (cmd_valid && ready) begin
                acc = cyc; in_cmd = 1; mcnt = '0;
                n_cfg = 0; n_clr = 0; n_enh = 0;
                cfg_lat = -1; clr_lat = -1; first_enh = -1; last_enh = -1;
            end
        end
    end

    // Narrow-counter monitor: wrap model and done scoreboard.
    logic [CW2-1:0] mcnt2 = '0;
    always @(negedge clk) begin
        if (rst) begin
            mcnt2 = '0;
        end else begin
            chk("cnt2_model", int'(cnt2), int'(mcnt2));
            chk("clr_enh_excl2", int'(clr2 && enh2), 0);
            if (enh2) mcnt2 = mcnt2 + CW2'(1);
            if (done2) begin
                if (exp2_q.size() == 0) chk("unexpected_done2", 1, 0);
                else chk("done2_cnt", int'(cnt2), exp2_q.pop_front());
            end
            if (cmd_valid2 && ready2) mcnt2 = '0;
        end
    end

    initial begin
        // Reset state
        tick(2);
        chk("rst_cfg", int'(cfg), 0);
        chk("rst_clr", int'(clr), 0);
        chk("rst_enh", int'(enh), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_amp", int'(amp), 0);
        rst = 1'b0;
        tick(1);
        chk("rst_ready", int'(ready), 1);
        tick(2);

        // Basic command
        push(4, 1, 3, 1, 1, 4, 1, 2, 3, 6, 7);
        send(SEL_COS, 8'd3, 16'd4);
        tick(9);

        // Backpressure for 3 cycles after the 2nd sample
        push(4, 3, 128, 1, 1, 4, 1, 2, 3, 9, 10);
        send(SEL_SQUA, 8'h80, 16'd4);
        tick(4);
        fifo_full = 1'b1;
        tick(3);
        fifo_full = 1'b0;
        tick(5);

        // Abort after 10 samples
        push(10, 2, 127, 1, 1, 10, 1, 2, 3, 12, 14);
        send(SEL_TRIAN, 8'h7f, 16'd100);
        tick(12);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(4);

        // Abort in CONFIG
        push(0, 1, 5, 1, 0, 0, 1, -1, -1, -1, 2);
        send(SEL_COS, 8'd5, 16'd8);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(4);

        // Back-to-back accepts with cmd_valid held high
        push(2, 2, 255, 1, 1, 2, 1, 2, 3, 4, 5);
        push(2, 2, 255, 1, 1, 2, 1, 2, 3, 4, 5);
        cmd_sel = SEL_TRIAN; cmd_amp = 8'hff; cmd_len = 16'd2; cmd_valid = 1'b1;
        tick(7);
        cmd_valid = 1'b0;
        tick(8);

        // Continuous mode on the 4-bit counter: 20 samples wrap to 4, then abort
        exp2_q.push_back(4);
        cmd_sel = SEL_TRIAN; cmd_amp = 8'hfb; cmd_len = 16'd0; cmd_valid2 = 1'b1;
        tick(1);
        cmd_valid2 = 1'b0;
        tick(22);
        chk("cont_busy", int'(busy2), 1);
        chk("cont_no_done", int'(done2), 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);

        // Reset mid-RUN with 5 samples issued: no done pulse follows
        send(SEL_SIN, 8'd1, 16'd20);
        tick(7);
        chk("pre_rst_cnt", int'(cnt), 5);
        rst = 1'b1;
        #1;
        chk("midrst_cfg", int'(cfg), 0);
        chk("midrst_clr", int'(clr), 0);
        chk("midrst_enh", int'(enh), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_cnt", int'(cnt), 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("postrst_ready", int'(ready), 1);
        chk("postrst_busy", int'(busy), 0);
        tick(5);

        // Drain: every expected completion must have been seen
        for (int i = 0; i < 50 && (exp_q.size() + exp2_q.size()) != 0; i++) tick(1);
        chk("queue_drain", exp_q.size() + exp2_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
